div_tap_tick_gen: RTL

Consumer of the 22-bit ripple divider output bus. Brings every divided clock into the CLK_IN domain through a two-flop synchroniser. Turns rising edges of one run-time-selected tap into single-cycle TICK enables, so downstream logic runs on CLK_IN with a clock enable instead of on ripple clocks. Tap changes are glitch-free: a new selection takes effect only on a tick boundary of the current tap, and the block keeps a wrap-around tick counter.

---
 rtl/div_tap_tick_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/div_tap_tick_gen.sv
// Synchronises a ripple-divider bus into the system clock domain and turns rising
// edges of one selectable tap into single-cycle tick enables with glitch-free tap switching.
module div_tap_tick_gen #(
  parameter int NTAPS = 22,
  parameter int CNT_W = 16
) (
  input  logic             clk_in_i,
  input  logic             rst_n_i,
  input  logic [NTAPS-1:0] div_bus_i,
  input  logic [4:0]       sel_i,
  input  logic             sel_valid_i,
  output logic             sel_ack_o,
  output logic             sel_err_o,
  output logic [4:0]       active_sel_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] tick_cnt_o
);

  localparam logic [4:0] NTAPS_L = 5'(NTAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NTAPS-1:0] sync1_q, sync2_q;
  logic [4:0]       active_q, active_d;
  logic [4:0]       pend_q, pend_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;

  logic             req_ok;
  logic             req_bad;
  logic             ack_req;
  logic             rose;
  logic [4:0]       pend_next;

  // Next-state logic for the tap-selection FSM, edge detector and tick counter.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pend_d    = pend_q;
    prev_d    = prev_q;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    req_ok    = sel_valid_i && (sel_i < NTAPS_L);
    req_bad   = sel_valid_i && !(sel_i < NTAPS_L);
    ack_req   = hold_q;
    rose      = sync2_q[active_q] & ~prev_q;
    pend_next = req_ok ? sel_i : pend_q;

    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          state_d  = ST_RUN;
          active_d = sel_i;
          prev_d   = sync2_q[sel_i];
          cnt_d    = {CNT_W{1'b0}};
          ack_req  = 1'b1;
        end else begin
          prev_d   = prev_q;
        end
      end
      ST_RUN: begin
        prev_d = sync2_q[active_q];
        tick_d = rose;
        if (rose) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (req_ok && (sel_i == active_q)) begin
          ack_req = 1'b1;
        end else if (req_ok) begin
          pend_d  = sel_i;
          state_d = ST_PEND;
        end else begin
          pend_d  = pend_q;
        end
      end
      ST_PEND: begin
        pend_d = pend_next;
        // The old tap's tick is on the output now: switch on this boundary.
        if (tick_q) begin
          state_d  = ST_RUN;
          active_d = pend_next;
          prev_d   = sync2_q[pend_next];
          cnt_d    = {CNT_W{1'b0}};
          ack_req  = 1'b1;
        end else begin
          prev_d   = sync2_q[active_q];
          tick_d   = rose;
          if (rose) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An ack colliding with an error pulse is held back one cycle.
    ack_d  = ack_req && !req_bad;
    hold_d = ack_req && req_bad;
    err_d  = req_bad;
  end

  // Synchronisers and all FSM/output registers.
  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      sync1_q  <= {NTAPS{1'b0}};
      sync2_q  <= {NTAPS{1'b0}};
      active_q <= 5'd0;
      pend_q   <= 5'd0;
      prev_q   <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= div_bus_i;
      sync2_q  <= sync1_q;
      active_q <= active_d;
      pend_q   <= pend_d;
      prev_q   <= prev_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  assign sel_ack_o    = ack_q;
  assign sel_err_o    = err_q;
  assign active_sel_o = active_q;
  assign tick_o       = tick_q;
  assign tick_cnt_o   = cnt_q;

endmodule
